// File: rtl/mskaes_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mskaes_gen_pkg
// Description : Shared definitions for the masked-AES control generator:
//               controller state encoding, round counts for AES-128/256 and
//               the legal configuration ranges with a helper to check them.
// Revision    : 1.0 - initial release
// ============================================================================
package mskaes_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_KSB   = 3'd2,
        ST_SSB   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_AKF   = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    localparam logic [3:0] c_nr_128     = 4'd10;
    localparam logic [3:0] c_nr_256     = 4'd14;
    localparam int         c_sb_lat_min = 1;
    localparam int         c_sb_lat_max = 8;

    // Lane counts must divide the 16 state bytes into whole columns.
    function automatic logic cfg_legal(input int nsb, input int sb_lat);
        logic nsb_ok;
        logic lat_ok;
        nsb_ok = (nsb == 4) || (nsb == 8) || (nsb == 16);
        lat_ok = (sb_lat >= c_sb_lat_min) && (sb_lat <= c_sb_lat_max);
        return nsb_ok && lat_ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mskaes_gen_sched_cnt.sv
`default_nettype none
// ============================================================================
// Module      : mskaes_gen_sched_cnt
// Description : Round counter (4 bit) and shared column/drain counter (3 bit)
//               with terminal-count flags for the masked-AES controller.
// Ports       : clk, rst         - clock, async active-high reset
//               i_rnd_load       - set round counter to 1
//               i_rnd_inc        - advance round (saturates at i_nr)
//               i_cnt_clr/inc    - clear / advance phase counter
//               i_nr             - number of rounds of the current job
//               o_rnd_even       - current round number is even
//               o_rnd_last       - current round is the final round
//               o_col_tc/o_drn_tc- last column / last drain cycle
// Revision    : 1.0 - initial release
// ============================================================================
module mskaes_gen_sched_cnt #(
    parameter int COL_CYCLES = 4,
    parameter int DRN_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rnd_load,
    input  logic       i_rnd_inc,
    input  logic       i_cnt_clr,
    input  logic       i_cnt_inc,
    input  logic [3:0] i_nr,
    output logic       o_rnd_even,
    output logic       o_rnd_last,
    output logic       o_col_tc,
    output logic       o_drn_tc
);

    localparam logic [2:0] c_col_last = 3'(COL_CYCLES - 1);
    localparam logic [2:0] c_drn_last = 3'(DRN_CYCLES - 1);

    logic [3:0] r_rnd;
    logic [2:0] r_cnt;

    // Both counters saturate so a stray enable can never wrap them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rnd <= 4'd0;
            r_cnt <= 3'd0;
        end else begin
            if (i_rnd_load) begin
                r_rnd <= 4'd1;
            end else if (i_rnd_inc && (r_rnd != i_nr)) begin
                r_rnd <= r_rnd + 4'd1;
            end
            if (i_cnt_clr) begin
                r_cnt <= 3'd0;
            end else if (i_cnt_inc && (r_cnt != 3'd7)) begin
                r_cnt <= r_cnt + 3'd1;
            end
        end
    end

    assign o_rnd_even = ~r_rnd[0];
    assign o_rnd_last = (r_rnd == i_nr);
    assign o_col_tc   = (r_cnt == c_col_last);
    assign o_drn_tc   = (r_cnt == c_drn_last);

endmodule
`default_nettype wire

// File: rtl/mskaes_gen_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mskaes_gen_fsm
// Description : Control generator for a masked AES core with NSB Sbox lanes
//               and an SB_LAT-cycle Sbox pipeline. Sequences INIT, Nr rounds
//               of key Sbox / state Sbox / drain, the final key addition and
//               the output handshake.
// Ports       : clk, rst (async, active-high)
//               valid_in/in_ready, cipher_valid/out_ready - job handshakes
//               key256, inverse - job mode, sampled on acceptance
//               busy and all datapath / Sbox / rcon / randomness strobes
// Revision    : 1.0 - initial release
// ============================================================================
module mskaes_gen_fsm
    import mskaes_gen_pkg::*;
#(
    parameter int NSB    = 4,
    parameter int SB_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic valid_in,
    input  logic key256,
    input  logic inverse,
    input  logic out_ready,
    output logic in_ready,
    output logic busy,
    output logic cipher_valid,
    output logic global_init,
    output logic state_init,
    output logic KH_init,
    output logic state_enable,
    output logic KH_enable,
    output logic state_en_MC,
    output logic state_en_loop,
    output logic KH_loop,
    output logic KH_odd_round,
    output logic feed_sb_key,
    output logic sbox_valid_in,
    output logic inverse_sbox_in,
    output logic enable_key_add,
    output logic in_AKfinal,
    output logic rcon_rst,
    output logic rcon_update,
    output logic rnd_req
);

    localparam int c_cols = 16 / NSB;

    if (!cfg_legal(NSB, SB_LAT)) begin : g_cfg_check
        $error("mskaes_gen_fsm: illegal NSB/SB_LAT configuration");
    end

    state_t     r_state;
    logic       r_key256;
    logic       r_inverse;
    logic [3:0] w_nr;
    logic       w_rnd_even, w_rnd_last, w_col_tc, w_drn_tc;
    logic       w_rnd_load, w_rnd_inc, w_cnt_clr, w_cnt_inc;

    assign w_nr = r_key256 ? c_nr_256 : c_nr_128;

    // Counter control: the phase counter restarts at the end of each
    // multi-cycle phase, so every phase begins counting from zero.
    assign w_rnd_load = (r_state == ST_INIT);
    assign w_rnd_inc  = (r_state == ST_DRAIN) && w_drn_tc && !w_rnd_last;
    assign w_cnt_clr  = (r_state == ST_INIT)
                      || ((r_state == ST_SSB)   && w_col_tc)
                      || ((r_state == ST_DRAIN) && w_drn_tc)
                      || ((r_state == ST_AKF)   && w_col_tc);
    assign w_cnt_inc  = ((r_state == ST_SSB) || (r_state == ST_DRAIN)
                      || (r_state == ST_AKF)) && !w_cnt_clr;

    mskaes_gen_sched_cnt #(
        .COL_CYCLES (c_cols),
        .DRN_CYCLES (SB_LAT)
    ) u_sched_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_rnd_load (w_rnd_load),
        .i_rnd_inc  (w_rnd_inc),
        .i_cnt_clr  (w_cnt_clr),
        .i_cnt_inc  (w_cnt_inc),
        .i_nr       (w_nr),
        .o_rnd_even (w_rnd_even),
        .o_rnd_last (w_rnd_last),
        .o_col_tc   (w_col_tc),
        .o_drn_tc   (w_drn_tc)
    );

    // Mode bits are only captured in IDLE, so activity on valid_in/key256/
    // inverse during a job cannot disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_key256  <= 1'b0;
            r_inverse <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (valid_in) begin
                        r_key256  <= key256;
                        r_inverse <= inverse;
                        r_state   <= ST_INIT;
                    end
                end
                ST_INIT:  r_state <= ST_KSB;
                ST_KSB:   r_state <= ST_SSB;
                ST_SSB:   if (w_col_tc) r_state <= ST_DRAIN;
                ST_DRAIN: if (w_drn_tc) r_state <= w_rnd_last ? ST_AKF : ST_KSB;
                ST_AKF:   if (w_col_tc) r_state <= ST_DONE;
                ST_DONE:  if (out_ready) r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // Outputs depend only on registered state, latched mode and counter
    // flags; no input reaches an output combinationally.
    always_comb begin
        in_ready        = 1'b0;
        busy            = 1'b1;
        cipher_valid    = 1'b0;
        global_init     = 1'b0;
        state_init      = 1'b0;
        KH_init         = 1'b0;
        state_enable    = 1'b0;
        KH_enable       = 1'b0;
        state_en_MC     = 1'b0;
        state_en_loop   = 1'b0;
        KH_loop         = 1'b0;
        KH_odd_round    = 1'b0;
        feed_sb_key     = 1'b0;
        sbox_valid_in   = 1'b0;
        inverse_sbox_in = 1'b0;
        enable_key_add  = 1'b0;
        in_AKfinal      = 1'b0;
        rcon_rst        = 1'b0;
        rcon_update     = 1'b0;
        rnd_req         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            ST_INIT: begin
                global_init = 1'b1;
                state_init  = 1'b1;
                KH_init     = 1'b1;
                rcon_rst    = 1'b1;
                rnd_req     = 1'b1;  // randomness must lead the first KSB
            end
            ST_KSB: begin
                feed_sb_key   = 1'b1;
                sbox_valid_in = 1'b1;
                KH_odd_round  = r_key256 & w_rnd_even;
                rnd_req       = 1'b1;
            end
            ST_SSB: begin
                sbox_valid_in   = 1'b1;
                state_enable    = 1'b1;
                enable_key_add  = 1'b1;
                inverse_sbox_in = r_inverse;
                state_en_MC     = !w_rnd_last;
                rnd_req         = 1'b1;
            end
            ST_DRAIN: begin
                KH_enable     = 1'b1;
                state_en_loop = 1'b1;
                rnd_req       = 1'b1;
                if (w_drn_tc) begin
                    KH_loop     = 1'b1;
                    // AES-256 odd key halves use SubWord without RotWord/rcon.
                    rcon_update = !(r_key256 & w_rnd_even);
                end
            end
            ST_AKF: begin
                in_AKfinal     = 1'b1;
                enable_key_add = 1'b1;
                state_enable   = 1'b1;
            end
            ST_DONE: begin
                cipher_valid = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mskaes_gen_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_mskaes_gen_fsm
// Description : Self-checking bench. Two controllers (NSB=4 and NSB=16, both
//               SB_LAT=4) are run with randomized jobs; every cycle the full
//               output vector is compared with a schedule model derived from
//               the job's phase arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mskaes_gen_fsm;

    typedef struct packed {
        logic in_ready, busy, cipher_valid;
        logic global_init, state_init, KH_init;
        logic state_enable, KH_enable, state_en_MC, state_en_loop, KH_loop, KH_odd_round;
        logic feed_sb_key, sbox_valid_in, inverse_sbox_in, enable_key_add, in_AKfinal;
        logic rcon_rst, rcon_update, rnd_req;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] valid_in  = '0;
    logic [1:0] key256    = '0;
    logic [1:0] inverse   = '0;
    logic [1:0] out_ready = '0;
    wire  [19:0] oa;
    wire  [19:0] ob;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mskaes_gen_fsm #(.NSB(4), .SB_LAT(4)) u_dut_a (
        .clk(clk), .rst(rst), .valid_in(valid_in[0]), .key256(key256[0]),
        .inverse(inverse[0]), .out_ready(out_ready[0]),
        .in_ready(oa[19]), .busy(oa[18]), .cipher_valid(oa[17]),
        .global_init(oa[16]), .state_init(oa[15]), .KH_init(oa[14]),
        .state_enable(oa[13]), .KH_enable(oa[12]), .state_en_MC(oa[11]),
        .state_en_loop(oa[10]), .KH_loop(oa[9]), .KH_odd_round(oa[8]),
        .feed_sb_key(oa[7]), .sbox_valid_in(oa[6]), .inverse_sbox_in(oa[5]),
        .enable_key_add(oa[4]), .in_AKfinal(oa[3]), .rcon_rst(oa[2]),
        .rcon_update(oa[1]), .rnd_req(oa[0])
    );

    mskaes_gen_fsm #(.NSB(16), .SB_LAT(4)) u_dut_b (
        .clk(clk), .rst(rst), .valid_in(valid_in[1]), .key256(key256[1]),
        .inverse(inverse[1]), .out_ready(out_ready[1]),
        .in_ready(ob[19]), .busy(ob[18]), .cipher_valid(ob[17]),
        .global_init(ob[16]), .state_init(ob[15]), .KH_init(ob[14]),
        .state_enable(ob[13]), .KH_enable(ob[12]), .state_en_MC(ob[11]),
        .state_en_loop(ob[10]), .KH_loop(ob[9]), .KH_odd_round(ob[8]),
        .feed_sb_key(ob[7]), .sbox_valid_in(ob[6]), .inverse_sbox_in(ob[5]),
        .enable_key_add(ob[4]), .in_AKfinal(ob[3]), .rcon_rst(ob[2]),
        .rcon_update(ob[1]), .rnd_req(ob[0])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] obs(input int u);
        return (u == 0) ? oa : ob;
    endfunction

    // Expected outputs k cycles after the acceptance edge (k<0: idle).
    // Timeline: 1 init cycle, nr rounds of (1 key Sbox + c state Sbox +
    // l drain), c final key-add cycles, then done.
    function automatic logic [19:0] model(input int k, input int nr, input int c,
                                          input int l, input bit k256, input bit inv);
        outs_t o;
        int    rl, off, r, p;
        o  = '0;
        rl = 1 + c + l;
        if (k < 0) begin
            o.in_ready = 1'b1;
            return o;
        end
        o.busy = 1'b1;
        if (k == 0) begin
            o.global_init = 1; o.state_init = 1; o.KH_init = 1;
            o.rcon_rst = 1; o.rnd_req = 1;
        end else if (k <= nr * rl) begin
            off = k - 1;
            r   = off / rl + 1;
            p   = off % rl;
            o.rnd_req = 1;
            if (p == 0) begin
                o.feed_sb_key = 1; o.sbox_valid_in = 1;
                o.KH_odd_round = k256 && (r % 2 == 0);
            end else if (p <= c) begin
                o.sbox_valid_in = 1; o.state_enable = 1; o.enable_key_add = 1;
                o.inverse_sbox_in = inv;
                o.state_en_MC = (r != nr);
            end else begin
                o.KH_enable = 1; o.state_en_loop = 1;
                if (p == rl - 1) begin
                    o.KH_loop = 1;
                    o.rcon_update = !(k256 && (r % 2 == 0));
                end
            end
        end else if (k <= nr * rl + c) begin
            o.in_AKfinal = 1; o.enable_key_add = 1; o.state_enable = 1;
        end else begin
            o.cipher_valid = 1;
        end
        return o;
    endfunction

    // One job on unit u. hold = cycles of out_ready=0 while done; noisy
    // scrambles valid_in/key256/inverse/out_ready while busy; abort_k >= 0
    // asserts rst asynchronously in that cycle.
    task automatic run_job(input int u, input bit k256, input bit inv, input int hold,
                           input bit noisy, input int abort_k);
        int c, l, nr, done, first;
        c     = (u == 0) ? 4 : 1;
        l     = 4;
        nr    = k256 ? 14 : 10;
        done  = 1 + nr * (1 + c + l) + c;
        first = -1;
        @(negedge clk);
        check("idle_before", obs(u), model(-1, nr, c, l, k256, inv));
        valid_in[u]  = 1'b1;
        key256[u]    = k256;
        inverse[u]   = inv;
        out_ready[u] = 1'($urandom);
        for (int k = 0; k <= done + hold; k++) begin
            @(negedge clk);
            check($sformatf("u%0d_cyc%0d", u, k), obs(u), model(k, nr, c, l, k256, inv));
            if (obs(u)[17] && first < 0) first = k;
            if (k == abort_k) begin
                #2;
                rst          = 1'b1;
                valid_in[u]  = 1'b0;
                out_ready[u] = 1'b0;
                #1;
                check("rst_async_a", {12'd0, oa & 20'h7FFFF}, 32'd0);
                check("rst_async_b", {12'd0, ob & 20'h7FFFF}, 32'd0);
                @(negedge clk);
                rst = 1'b0;
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    check("post_abort_idle", obs(u), model(-1, nr, c, l, k256, inv));
                end
                return;
            end
            if (noisy) begin
                valid_in[u] = 1'($urandom);
                key256[u]   = 1'($urandom);
                inverse[u]  = 1'($urandom);
            end else begin
                valid_in[u] = 1'b0;
            end
            if (k < done)             out_ready[u] = 1'($urandom);
            else if (k < done + hold) out_ready[u] = 1'b0;
            else                      out_ready[u] = 1'b1;
        end
        @(negedge clk);
        check("back_to_idle", obs(u), model(-1, nr, c, l, k256, inv));
        valid_in[u]  = 1'b0;
        out_ready[u] = 1'b0;
        check("latency", first, done);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_held_a", {12'd0, oa & 20'h7FFFF}, 32'd0);
        check("rst_held_b", {12'd0, ob & 20'h7FFFF}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_rel_a", oa, 20'h80000);
        check("rst_rel_b", ob, 20'h80000);

        run_job(0, 1'b0, 1'b0, 0, 1'b0, -1);        // AES-128, latency 95
        run_job(0, 1'b1, 1'b1, 3, 1'b1, -1);        // AES-256, latency 131
        run_job(1, 1'b0, 1'($urandom), 20, 1'b1, -1); // NSB=16, long hold
        run_job(0, 1'b0, 1'b1, 0, 1'b1, 38);        // reset in round 5 SSB
        run_job(0, 1'($urandom), 1'($urandom), 1, 1'b1, -1);
        run_job(1, 1'b1, 1'b0, 2, 1'b1, -1);
        for (int j = 0; j < 4; j++) begin
            run_job(int'($urandom_range(0, 1)), 1'($urandom), 1'($urandom),
                    int'($urandom_range(0, 5)), 1'b1, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
